// File: rtl/image_processor_pkg.sv
// Shared Q16.16 constants, coefficient indexing and FSM state for the colour-correction engine.
package image_processor_pkg;

  localparam int FRAC_BITS = 16;
  localparam int NUM_ROWS  = 3;
  localparam int CH_W      = 8;
  localparam int COEF_W    = 32;
  localparam int PROD_W    = 41;  // 32-bit signed coef x 9-bit signed (zero-extended) channel
  localparam int SUM_W     = 43;  // three products plus rounding headroom

  localparam logic [COEF_W-1:0] ONE   = 32'h0001_0000;
  localparam logic [SUM_W-1:0]  ROUND = 43'h000_0000_8000;

  // Element k sits at bits [32k+31:32k]; diagonal k=0,4,8 carries 1.0.
  localparam logic [9*COEF_W-1:0] IDENTITY = {
    ONE,   32'h0, 32'h0,
    32'h0, ONE,   32'h0,
    32'h0, 32'h0, ONE
  };

  function automatic int coef_idx(input int row, input int col);
    return row * 3 + col;
  endfunction

  typedef enum logic [1:0] {IDLE, MULT, ACC} state_t;

endpackage

// File: rtl/cc_row_mac.sv
// One output channel: three registered products, then rounded/shifted/clamped sum.
module cc_row_mac #(
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mul_en,
  input  logic             acc_en,
  input  logic [2:0][31:0] coef,
  input  logic [2:0][7:0]  ch,
  output logic [7:0]       result
);
  import image_processor_pkg::*;

  logic signed [PROD_W-1:0] prod [3];
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  shifted;
  logic [7:0]               clamped;

  // Stage 1: signed coefficient times zero-extended channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 3; j++) prod[j] <= '0;
    end else if (mul_en) begin
      for (int j = 0; j < 3; j++)
        prod[j] <= PROD_W'($signed(coef[j])) * PROD_W'($signed({1'b0, ch[j]}));
    end
  end

  // Row sum with round-half-up, arithmetic shift back to integer, clamp to a byte.
  always_comb begin
    sum     = SUM_W'(prod[0]) + SUM_W'(prod[1]) + SUM_W'(prod[2]) + $signed(ROUND);
    shifted = sum >>> FRAC_BITS;
    clamped = shifted[7:0];
    if (shifted < 0)                      clamped = 8'd0;
    else if (shifted > SUM_W'(sd255()))   clamped = 8'd255;
  end

  function automatic logic signed [SUM_W-1:0] sd255();
    return 43'sd255;
  endfunction

  // Stage 2: result register holds until the next pixel completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      result <= '0;
    else if (acc_en) result <= clamped;
  end

endmodule

// File: rtl/image_processor.sv
// Per-pixel 3x3 Q16.16 colour correction with valid/ready input and one-cycle output strobe.
module image_processor #(
  parameter int FRAC_BITS = 16,
  parameter int LATENCY   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [23:0]  input_rgb,
  input  logic         input_valid,
  output logic         input_ready,
  input  logic [287:0] comp_matrix,
  input  logic         matrix_valid,
  output logic [23:0]  output_rgb,
  output logic         output_valid,
  output logic         busy
);
  import image_processor_pkg::*;

  state_t            state;
  logic [23:0]       pix;
  logic [8:0][31:0]  coef;
  logic [2:0][7:0]   row_out;
  logic [2:0][7:0]   chan;

  assign busy        = (state != IDLE);
  assign input_ready = ~busy;
  assign chan        = {pix[7:0], pix[15:8], pix[23:16]};  // index 0=R, 1=G, 2=B
  assign output_rgb  = {row_out[0], row_out[1], row_out[2]};

  // Control: the coefficient register only moves in IDLE, so an in-flight pixel
  // always sees the matrix captured on its acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pix          <= '0;
      coef         <= IDENTITY;
      output_valid <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (matrix_valid) coef <= comp_matrix;
          if (input_valid) begin
            pix   <= input_rgb;
            state <= MULT;
          end
        end
        MULT: state <= ACC;
        ACC: begin
          state        <= IDLE;
          output_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    cc_row_mac #(.FRAC_BITS(FRAC_BITS)) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .mul_en (state == MULT),
      .acc_en (state == ACC),
      .coef   ({coef[coef_idx(r, 2)], coef[coef_idx(r, 1)], coef[coef_idx(r, 0)]}),
      .ch     (chan),
      .result (row_out[r])
    );
  end

endmodule

// File: tb/tb_image_processor.sv
// Directed bench for image_processor: reset, identity, scaling, clamping, busy filtering, abort.
module tb_image_processor;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [23:0]  input_rgb = '0;
  logic         input_valid = 1'b0;
  logic         input_ready;
  logic [287:0] comp_matrix = '0;
  logic         matrix_valid = 1'b0;
  logic [23:0]  output_rgb;
  logic         output_valid;
  logic         busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  image_processor dut (
    .clk(clk), .rst_n(rst_n), .input_rgb(input_rgb), .input_valid(input_valid),
    .input_ready(input_ready), .comp_matrix(comp_matrix), .matrix_valid(matrix_valid),
    .output_rgb(output_rgb), .output_valid(output_valid), .busy(busy)
  );

  function automatic logic [287:0] diag(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [8:0][31:0] m;
    m = '0;
    m[0] = a; m[4] = b; m[8] = c;
    return m;
  endfunction

  logic [287:0] mat_a;
  logic [287:0] mat_id;

  // Accept one pixel; report first result, its latency in edges (acceptance = 1),
  // number of strobes seen and busy after acceptance / after the next two edges.
  task automatic run_pixel(input logic [23:0] p, input logic mv, input logic [287:0] m,
                           output logic [23:0] res, output int lat, output int pulses,
                           output logic [2:0] btrace);
    @(negedge clk);
    input_rgb = p; input_valid = 1'b1; matrix_valid = mv; comp_matrix = m;
    @(posedge clk); #1;
    input_valid = 1'b0; matrix_valid = 1'b0;
    btrace[0] = busy;
    lat = 0; pulses = 0; res = 'x;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i <= 2) btrace[i] = busy;
      if (output_valid) begin
        pulses++;
        if (lat == 0) begin lat = i + 1; res = output_rgb; end
      end
    end
  endtask

  task automatic load_matrix(input logic [287:0] m);
    @(negedge clk);
    comp_matrix = m; matrix_valid = 1'b1;
    @(negedge clk);
    matrix_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (output_rgb !== 24'h0 || output_valid !== 1'b0 || busy !== 1'b0 || input_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: rgb=%h ov=%b busy=%b rdy=%b required 000000 0 0 1",
               output_rgb, output_valid, busy, input_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (input_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_reset: got %b required 1", input_ready);
    end
  endtask

  task automatic test_identity_default();
    logic [23:0] r; int lat, pl; logic [2:0] bt;
    run_pixel({8'd100, 8'd150, 8'd200}, 1'b0, '0, r, lat, pl, bt);
    checks++;
    if (r !== {8'd100, 8'd150, 8'd200}) begin
      failures++; $display("FAIL identity_rgb: got %h required 6496c8", r);
    end
  endtask

  task automatic test_scale();
    logic [23:0] r; int lat, pl; logic [2:0] bt;
    load_matrix(mat_a);
    run_pixel({8'd200, 8'd150, 8'd100}, 1'b0, '0, r, lat, pl, bt);
    checks++;
    if (r !== {8'd220, 8'd157, 8'd90}) begin
      failures++; $display("FAIL scale_rgb: got %h required dc9d5a", r);
    end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL scale_latency: got %0d required 3", lat); end
    checks++;
    if (pl !== 1) begin failures++; $display("FAIL scale_strobe_count: got %0d required 1", pl); end
    checks++;
    if (bt !== 3'b011) begin failures++; $display("FAIL scale_busy_trace: got %b required 011", bt); end
  endtask

  task automatic test_clamp_high();
    logic [23:0] r; int lat, pl; logic [2:0] bt;
    run_pixel({8'd255, 8'd255, 8'd255}, 1'b0, '0, r, lat, pl, bt);
    checks++;
    if (r !== {8'd255, 8'd255, 8'd229}) begin
      failures++; $display("FAIL clamp_high_rgb: got %h required ffffe5", r);
    end
  endtask

  task automatic test_clamp_neg();
    logic [23:0] r; int lat, pl; logic [2:0] bt;
    logic [8:0][31:0] m;
    m = mat_id;
    m[1] = 32'hFFFF_0000;
    load_matrix(m);
    run_pixel({8'd10, 8'd50, 8'd0}, 1'b0, '0, r, lat, pl, bt);
    checks++;
    if (r !== {8'd0, 8'd50, 8'd0}) begin
      failures++; $display("FAIL clamp_neg_rgb: got %h required 003200", r);
    end
  endtask

  task automatic test_busy_ignore();
    logic [23:0] r, first; int pulses, lat, pl; logic [2:0] bt;
    load_matrix(mat_a);
    @(negedge clk);
    input_rgb = {8'd200, 8'd150, 8'd100}; input_valid = 1'b1;
    @(posedge clk); #1;
    input_rgb = {8'd1, 8'd2, 8'd3}; matrix_valid = 1'b1; comp_matrix = mat_id;
    @(posedge clk); #1;
    input_valid = 1'b0;
    @(negedge clk);
    input_valid = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0; matrix_valid = 1'b0;
    pulses = 0; first = 'x;
    if (output_valid) begin pulses++; first = output_rgb; end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (output_valid) pulses++;
    end
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL busy_single_output: got %0d required 1", pulses); end
    checks++;
    if (first !== {8'd220, 8'd157, 8'd90}) begin
      failures++; $display("FAIL busy_old_matrix: got %h required dc9d5a", first);
    end
    // Matrix is still A; the same pixel rerun must match A again.
    run_pixel({8'd200, 8'd150, 8'd100}, 1'b0, '0, r, lat, pl, bt);
    checks++;
    if (r !== {8'd220, 8'd157, 8'd90}) begin
      failures++; $display("FAIL busy_matrix_not_loaded: got %h required dc9d5a", r);
    end
    // Same-edge load: identity arrives with the pixel and is used by it.
    run_pixel({8'd200, 8'd150, 8'd100}, 1'b1, mat_id, r, lat, pl, bt);
    checks++;
    if (r !== {8'd200, 8'd150, 8'd100}) begin
      failures++; $display("FAIL same_edge_load: got %h required c89664", r);
    end
  endtask

  task automatic test_abort();
    logic [23:0] r; int lat, pl, strobes; logic [2:0] bt;
    load_matrix(mat_a);
    @(negedge clk);
    input_rgb = {8'd200, 8'd150, 8'd100}; input_valid = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_mult: got %b required 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (output_rgb !== 24'h0 || output_valid !== 1'b0 || busy !== 1'b0 || input_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_reset_outputs: rgb=%h ov=%b busy=%b rdy=%b required 000000 0 0 1",
               output_rgb, output_valid, busy, input_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (output_valid) strobes++;
    end
    checks++;
    if (strobes !== 0) begin failures++; $display("FAIL abort_no_output: got %0d required 0", strobes); end
    run_pixel({8'd100, 8'd150, 8'd200}, 1'b0, '0, r, lat, pl, bt);
    checks++;
    if (r !== {8'd100, 8'd150, 8'd200}) begin
      failures++; $display("FAIL abort_identity_after: got %h required 6496c8", r);
    end
  endtask

  initial begin
    mat_a  = diag(32'h0001_1999, 32'h0001_0CCC, 32'h0000_E666);
    mat_id = diag(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    test_reset();
    test_identity_default();
    test_scale();
    test_clamp_high();
    test_clamp_neg();
    test_busy_ignore();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
